noc_input_port: RTL and testbench
=================================

Name: noc_input_port

Overview:
Input stage of a 5-port mesh router. It buffers incoming flits in a small FIFO and computes the XY-route port select for each flit when the flit is written. It then presents the head flit plus its 3-bit select to the downstream demux1to5, which steers the flit to N/E/S/W/Local. Flow control is valid/ready on both sides.

Parameters:
DATA_W, 32, flit width in bits
DEPTH, 4, FIFO entries (power of 2, >=2)
COORD_W, 2, bits per X/Y coordinate (4x4 mesh)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
cur_x  input  COORD_W  this router's X coordinate (static)
cur_y  input  COORD_W  this router's Y coordinate (static)
in_valid  input  1  upstream flit valid
in_data  input  DATA_W  upstream flit; dst_x = in_data[COORD_W-1:0], dst_y = in_data[2*COORD_W-1:COORD_W]
in_ready  output  1  FIFO can accept a flit this cycle
out_valid  output  1  head flit available
out_data  output  DATA_W  head flit
out_sel  output  3  demux select for head flit
out_ready  input  1  downstream consumes head this cycle
overflow  output  1  sticky error: in_valid seen while in_ready low

Behaviour:
- Reset (synchronous, active-high, sampled on the clk edge):
  - wr_ptr, rd_ptr and count go to 0.
  - overflow goes to 0.
  - Outputs after reset: out_valid=0, out_data=0, out_sel=0, in_ready=1.
  - Reset mid-operation discards all stored flits.
- Select encoding, shared with demux1to5: 0=Local, 1=North, 2=East, 3=South, 4=West. Values 5-7 are never produced.
- XY route, computed combinationally on in_data and stored in a parallel sel array at write:
  - dst_x>cur_x gives East; dst_x<cur_x gives West.
  - Otherwise dst_y>cur_y gives North; dst_y<cur_y gives South.
  - Otherwise Local.
  - Comparisons are unsigned.
- in_ready = (count != DEPTH). It has no combinational dependence on out_ready, so there is no bypass when full.
- Push occurs when in_valid && in_ready. The flit and its sel are written at wr_ptr, and wr_ptr increments modulo DEPTH, wrapping naturally via log2(DEPTH) bits.
- Pop occurs when out_valid && out_ready. rd_ptr increments modulo DEPTH.
- count update: push only gives +1; pop only gives -1; push and pop together leave count unchanged.
- out_valid = (count != 0).
- out_data and out_sel show the mem/sel entry at rd_ptr when out_valid=1, and are forced to 0 when out_valid=0.
- Latency: a flit pushed on edge N is visible at the outputs after edge N (one cycle), including when the FIFO was empty. There is no write-to-read bypass.
- Full with pop and in_valid: in_ready is 0, so no push. The pop completes; in_ready rises next cycle.
- Empty with push: no pop is possible in the same cycle (out_valid=0).
- Head stability: while out_valid=1 and out_ready=0, out_data and out_sel must hold stable.
- Overflow: set on any cycle with in_valid=1 and in_ready=0. It stays set until reset. The flit is dropped and FIFO state is unchanged.
- A flit's sel is decided once at write time. Later changes to cur_x/cur_y do not re-route stored flits.

Decomposition:
- Shared package noc_pkg holds:
  - port select constants (PORT_LOCAL=0 .. PORT_WEST=4)
  - SEL_W=3
  - COORD_W default
  - flit field offsets (DST_X_LSB, DST_Y_LSB)
  - These constants are also used by demux1to5 and its testbench.
- One sub-module: xy_route_compute. It is purely combinational, takes (cur_x, cur_y, dst_x, dst_y) and returns sel. It is instantiated on the write path and is unit-testable in isolation.
- FIFO storage, pointers and count stay in noc_input_port.

Test Plan:
1. Reset then idle: hold reset 2 cycles -> out_valid=0, out_data=0, out_sel=0, in_ready=1, overflow=0.
2. Route coverage: cur=(1,1); push one flit each with dst (2,1), (0,1), (1,2), (1,0), (1,1); out_ready=1 -> out_sel sequence 2,4,1,3,0, each one cycle after its push, data in order.
3. Fill/backpressure: out_ready=0; push flits 0xA0..0xA3 -> in_ready=0 after the 4th. Push 0xA4 -> overflow=1, 0xA4 dropped. Then out_ready=1 -> outputs 0xA0..0xA3 only, then out_valid=0.
4. Simultaneous push/pop: count=2, in_valid=1, out_ready=1 for 6 cycles -> count stays 2, outputs in order, and pointers wrap past DEPTH without loss.
5. Stall stability: head 0x55 with sel=2, out_ready=0 for 5 cycles while pushing 0x66 -> out_data=0x55, out_sel=2 unchanged throughout.
6. Reset mid-operation: 3 flits stored, overflow=1, assert reset one cycle -> out_valid=0, overflow=0, in_ready=1; the next pushed flit appears as the first output.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared mesh-router definitions: demux port-select encoding and flit header field positions.
package noc_pkg;
    localparam int COORD_W   = 2;
    localparam int SEL_W     = 3;
    localparam int DST_X_LSB = 0;
    localparam int DST_Y_LSB = COORD_W;

    typedef logic [SEL_W-1:0] sel_t;

    localparam sel_t PORT_LOCAL = 3'd0;
    localparam sel_t PORT_NORTH = 3'd1;
    localparam sel_t PORT_EAST  = 3'd2;
    localparam sel_t PORT_SOUTH = 3'd3;
    localparam sel_t PORT_WEST  = 3'd4;
endpackage

// File: rtl/xy_route_compute.sv
// Dimension-ordered (X first, then Y) route decision for one flit; purely combinational.
module xy_route_compute #(
    parameter int COORD_W = noc_pkg::COORD_W
) (
    input  logic [COORD_W-1:0]     cur_x,
    input  logic [COORD_W-1:0]     cur_y,
    input  logic [COORD_W-1:0]     dst_x,
    input  logic [COORD_W-1:0]     dst_y,
    output logic [noc_pkg::SEL_W-1:0] sel
);
    import noc_pkg::*;

    always_comb begin
        sel = PORT_LOCAL;
        if (dst_x > cur_x) begin
            sel = PORT_EAST;
        end else if (dst_x < cur_x) begin
            sel = PORT_WEST;
        end else if (dst_y > cur_y) begin
            sel = PORT_NORTH;
        end else if (dst_y < cur_y) begin
            sel = PORT_SOUTH;
        end
    end
endmodule

// File: rtl/noc_input_port.sv
// Router input stage: flit FIFO with the XY route select captured alongside each flit at write time.
module noc_input_port #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 4,
    parameter int COORD_W = noc_pkg::COORD_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [COORD_W-1:0]        cur_x,
    input  logic [COORD_W-1:0]        cur_y,
    input  logic                      in_valid,
    input  logic [DATA_W-1:0]         in_data,
    output logic                      in_ready,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic [noc_pkg::SEL_W-1:0] out_sel,
    input  logic                      out_ready,
    output logic                      overflow
);
    import noc_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem     [DEPTH];
    sel_t              sel_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic              push;
    logic              pop;
    sel_t              in_sel;

    // in_ready depends only on stored state, so a full FIFO never admits a flit in the pop cycle
    assign in_ready  = (count != FULL_CNT);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    xy_route_compute #(
        .COORD_W(COORD_W)
    ) u_route (
        .cur_x(cur_x),
        .cur_y(cur_y),
        .dst_x(in_data[DST_X_LSB +: COORD_W]),
        .dst_y(in_data[DST_X_LSB + COORD_W +: COORD_W]),
        .sel  (in_sel)
    );

    // Storage is data-only; stale entries are never visible because outputs are gated by count
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr]     <= in_data;
            sel_mem[wr_ptr] <= in_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (in_valid && !in_ready) begin
                overflow <= 1'b1;
            end
        end
    end

    assign out_data = out_valid ? mem[rd_ptr]     : '0;
    assign out_sel  = out_valid ? sel_mem[rd_ptr] : '0;
endmodule

// File: tb/tb_noc_input_port.sv
// Directed bench for noc_input_port: routing, fill/backpressure, streaming, stall hold and reset.
module tb_noc_input_port;
    localparam int DATA_W  = 32;
    localparam int DEPTH   = 4;
    localparam int COORD_W = 2;

    logic              clk;
    logic              reset;
    logic [COORD_W-1:0] cur_x;
    logic [COORD_W-1:0] cur_y;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [2:0]        out_sel;
    logic              out_ready;
    logic              overflow;

    int checks = 0;
    int fails  = 0;

    noc_input_port #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .COORD_W(COORD_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cur_x    (cur_x),
        .cur_y    (cur_y),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_sel  (out_sel),
        .out_ready(out_ready),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1 time unit so outputs reflect the new state
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        cur_x = 2'd1; cur_y = 2'd1;
        step();
        step();
        reset = 1'b0;
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (out_data !== 32'h0) begin fails++; $display("FAIL reset_out_data got %h want 0", out_data); end
        checks++; if (out_sel !== 3'd0) begin fails++; $display("FAIL reset_out_sel got %0d want 0", out_sel); end
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow got %b want 0", overflow); end
    endtask

    task automatic test_route();
        // low nibble = {dst_y, dst_x}; cur=(1,1)
        logic [31:0] data_v [5] = '{32'hC000_0106, 32'hC000_0204, 32'hC000_0309, 32'hC000_0401, 32'hC000_0505};
        logic [2:0]  sel_v  [5] = '{3'd2, 3'd4, 3'd1, 3'd3, 3'd0};
        cur_x = 2'd1; cur_y = 2'd1;
        for (int i = 0; i < 5; i++) begin
            in_data = data_v[i]; in_valid = 1'b1; out_ready = 1'b0;
            step();
            in_valid = 1'b0;
            checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL route_valid[%0d] got %b want 1", i, out_valid); end
            checks++; if (out_data !== data_v[i]) begin fails++; $display("FAIL route_data[%0d] got %h want %h", i, out_data, data_v[i]); end
            checks++; if (out_sel !== sel_v[i]) begin fails++; $display("FAIL route_sel[%0d] got %0d want %0d", i, out_sel, sel_v[i]); end
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL route_drained[%0d] got %b want 0", i, out_valid); end
        end
    endtask

    task automatic test_fill();
        logic [31:0] data_v [4] = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        logic [2:0]  sel_v  [4] = '{3'd4, 3'd3, 3'd2, 3'd2};
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL fill_ready_before[%0d] got %b want 1", i, in_ready); end
            in_data = data_v[i]; in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL fill_full_ready got %b want 0", in_ready); end
        checks++; if (overflow !== 1'b0) begin fails++; $display("FAIL fill_no_overflow_yet got %b want 0", overflow); end
        in_data = 32'hA4; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++; if (overflow !== 1'b1) begin fails++; $display("FAIL fill_overflow got %b want 1", overflow); end
        checks++; if (out_data !== 32'hA0) begin fails++; $display("FAIL fill_head_after_drop got %h want a0", out_data); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL fill_drain_valid[%0d] got %b want 1", i, out_valid); end
            checks++; if (out_data !== data_v[i]) begin fails++; $display("FAIL fill_drain_data[%0d] got %h want %h", i, out_data, data_v[i]); end
            checks++; if (out_sel !== sel_v[i]) begin fails++; $display("FAIL fill_drain_sel[%0d] got %0d want %0d", i, out_sel, sel_v[i]); end
            step();
            if (i == 0) begin
                checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL fill_ready_after_pop got %b want 1", in_ready); end
            end
        end
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL fill_empty got %b want 0", out_valid); end
        checks++; if (overflow !== 1'b1) begin fails++; $display("FAIL fill_overflow_sticky got %b want 1", overflow); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] data_v [8];
        for (int i = 0; i < 8; i++) data_v[i] = 32'hB000_0000 + 32'(i);
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_data = data_v[i]; in_valid = 1'b1;
            step();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_data = data_v[i + 2]; in_valid = 1'b1;
            checks++; if (out_data !== data_v[i]) begin fails++; $display("FAIL b2b_data[%0d] got %h want %h", i, out_data, data_v[i]); end
            step();
            checks++; if (dut.count !== 3'd2) begin fails++; $display("FAIL b2b_count[%0d] got %0d want 2", i, dut.count); end
            checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready[%0d] got %b want 1", i, in_ready); end
        end
        in_valid = 1'b0;
        for (int i = 6; i < 8; i++) begin
            checks++; if (out_data !== data_v[i]) begin fails++; $display("FAIL b2b_tail[%0d] got %h want %h", i, out_data, data_v[i]); end
            step();
        end
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_empty got %b want 0", out_valid); end
    endtask

    task automatic test_stall();
        cur_x = 2'd0; cur_y = 2'd0;
        out_ready = 1'b0;
        in_data = 32'h55; in_valid = 1'b1;
        step();
        in_data = 32'h66;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) cur_x = 2'd3;
            step();
            checks++; if (out_data !== 32'h55) begin fails++; $display("FAIL stall_data[%0d] got %h want 55", i, out_data); end
            checks++; if (out_sel !== 3'd2) begin fails++; $display("FAIL stall_sel[%0d] got %0d want 2", i, out_sel); end
        end
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL stall_full got %b want 0", in_ready); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++; if (overflow !== 1'b1) begin fails++; $display("FAIL mid_pre_overflow got %b want 1", overflow); end
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL mid_pre_ready got %b want 1", in_ready); end
        checks++; if (out_data !== 32'h66) begin fails++; $display("FAIL mid_pre_head got %h want 66", out_data); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_valid got %b want 0", out_valid); end
        checks++; if (overflow !== 1'b0) begin fails++; $display("FAIL mid_overflow got %b want 0", overflow); end
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL mid_ready got %b want 1", in_ready); end
        cur_x = 2'd1; cur_y = 2'd1;
        in_data = 32'h77; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++; if (out_data !== 32'h77) begin fails++; $display("FAIL mid_first_data got %h want 77", out_data); end
        checks++; if (out_sel !== 3'd2) begin fails++; $display("FAIL mid_first_sel got %0d want 2", out_sel); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_only_one got %b want 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_route();
        test_fill();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
